// File: rtl/ysyx_22040365_rf_pkg.sv
// Shared widths and read-FSM state encoding for the register-file access scheduler.
package ysyx_22040365_rf_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_22040365_rf_wb_arb.sv
// Round-robin EXU/LSU writeback arbiter merging both sources onto the single
// register-file write port; x0 writes handshake but never assert the write enable.
module ysyx_22040365_rf_wb_arb
  import ysyx_22040365_rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_exu_valid,
  input  logic [AW-1:0]   i_exu_addr,
  input  logic [XLEN-1:0] i_exu_data,
  output logic            o_exu_ready,
  input  logic            i_lsu_valid,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_data,
  output logic            o_lsu_ready,
  output logic            o_wen,
  output logic [AW-1:0]   o_waddr,
  output logic [XLEN-1:0] o_wdata
);

  logic r_prio_lsu;
  logic w_both;
  logic w_gnt_lsu;
  logic w_gnt_exu;

  assign w_both = i_exu_valid & i_lsu_valid;

  // Grant decode; the pointer only matters when both sources contend.
  always_comb begin
    w_gnt_lsu = 1'b0;
    w_gnt_exu = 1'b0;
    o_waddr   = {AW{1'b0}};
    o_wdata   = {XLEN{1'b0}};
    if (rst_n) begin
      w_gnt_lsu = i_lsu_valid & (~i_exu_valid | r_prio_lsu);
      w_gnt_exu = i_exu_valid & (~i_lsu_valid | ~r_prio_lsu);
    end else begin
      w_gnt_lsu = 1'b0;
      w_gnt_exu = 1'b0;
    end
    if (w_gnt_lsu) begin
      o_waddr = i_lsu_addr;
      o_wdata = i_lsu_data;
    end else if (w_gnt_exu) begin
      o_waddr = i_exu_addr;
      o_wdata = i_exu_data;
    end else begin
      o_waddr = {AW{1'b0}};
      o_wdata = {XLEN{1'b0}};
    end
  end

  assign o_lsu_ready = w_gnt_lsu;
  assign o_exu_ready = w_gnt_exu;
  assign o_wen       = (w_gnt_lsu | w_gnt_exu) & (o_waddr != {AW{1'b0}});

  // Last-grant pointer: flips only on contended grants, starts favouring LSU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_lsu <= 1'b1;
    end else if (w_both) begin
      r_prio_lsu <= ~r_prio_lsu;
    end
  end

endmodule

// File: rtl/ysyx_22040365_rf_sched.sv
// Register-file access scheduler: serialises rs1/rs2 onto one read port and
// arbitrates writebacks. Define YSYX_22040365_RF_BYPASS_EN to forward colliding writes.
module ysyx_22040365_rf_sched
  import ysyx_22040365_rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_src1,
  output logic [XLEN-1:0] resp_src2,
  input  logic            exu_wb_valid,
  output logic            exu_wb_ready,
  input  logic [AW-1:0]   exu_wb_addr,
  input  logic [XLEN-1:0] exu_wb_data,
  input  logic            lsu_wb_valid,
  output logic            lsu_wb_ready,
  input  logic [AW-1:0]   lsu_wb_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_ren_rs1,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic            w_rd_active;
  logic [AW-1:0]   w_raddr;
  logic [XLEN-1:0] w_rdata;
  logic            w_collide;
  logic            w_hold;
  logic [XLEN-1:0] w_cap_data;

  ysyx_22040365_rf_wb_arb u_wb_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_exu_valid (exu_wb_valid),
    .i_exu_addr  (exu_wb_addr),
    .i_exu_data  (exu_wb_data),
    .o_exu_ready (exu_wb_ready),
    .i_lsu_valid (lsu_wb_valid),
    .i_lsu_addr  (lsu_wb_addr),
    .i_lsu_data  (lsu_wb_data),
    .o_lsu_ready (lsu_wb_ready),
    .o_wen       (rf_wen),
    .o_waddr     (rf_waddr),
    .o_wdata     (rf_wdata)
  );

  assign w_rd_active = (r_state == RD1) | (r_state == RD2);
  assign w_raddr     = (r_state == RD1) ? r_rs1 : ((r_state == RD2) ? r_rs2 : {AW{1'b0}});
  assign w_rdata     = (w_raddr == {AW{1'b0}}) ? {XLEN{1'b0}} : rf_rdata;
  assign w_collide   = w_rd_active & (w_raddr != {AW{1'b0}}) & rf_wen & (rf_waddr == w_raddr);

`ifdef YSYX_22040365_RF_BYPASS_EN
  assign w_cap_data = w_collide ? rf_wdata : w_rdata;
  assign w_hold     = 1'b0;
`else
  // Without forwarding, stall one cycle so the re-read sees the landed write.
  assign w_cap_data = w_rdata;
  assign w_hold     = w_collide;
`endif

  // Read-sequencer next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_nxt = RD1;
        else           w_state_nxt = IDLE;
      end
      RD1: begin
        if (w_hold) w_state_nxt = RD1;
        else        w_state_nxt = RD2;
      end
      RD2: begin
        if (w_hold) w_state_nxt = RD2;
        else        w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
        else            w_state_nxt = RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched addresses and operand snapshots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1  <= {AW{1'b0}};
      r_rs2  <= {AW{1'b0}};
      r_src1 <= {XLEN{1'b0}};
      r_src2 <= {XLEN{1'b0}};
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_rs1 <= req_rs1;
        r_rs2 <= req_rs2;
      end
      if ((r_state == RD1) && !w_hold) r_src1 <= w_cap_data;
      if ((r_state == RD2) && !w_hold) r_src2 <= w_cap_data;
    end
  end

  assign req_ready  = rst_n & (r_state == IDLE);
  assign resp_valid = rst_n & (r_state == RESP);
  assign resp_src1  = r_src1;
  assign resp_src2  = r_src2;
  assign rf_raddr   = w_raddr;
  assign rf_ren_rs1 = rst_n & w_rd_active & (w_raddr != {AW{1'b0}});

endmodule
